// File: rtl/inst_seq.sv
// Instruction sequencer: replays a small program memory of {opcode, repeat} words into the
// decoder as a bubble-free stream, with loop, stall (hold) and abort control.
module inst_seq #(
  parameter int unsigned INST_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LOOP_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [15:0]           wr_data_i,
  input  logic [ADDR_WIDTH:0]   prog_len_i,
  input  logic [LOOP_WIDTH-1:0] num_loops_i,
  input  logic                  start_i,
  input  logic                  hold_i,
  input  logic                  abort_i,
  output logic                  inst_v_o,
  output logic [2:0]            opcode_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wr_err_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]            rep_q, rep_d;
  logic [LOOP_WIDTH-1:0] loop_q, loop_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [LOOP_WIDTH-1:0] loops_q, loops_d;

  logic                  inst_v_d, busy_d, done_d, wr_err_d;
  logic [2:0]            opcode_d;

  // Only the opcode and repeat fields are stored; the reserved byte is dropped.
  logic [7:0]            mem_q [INST_DEPTH];
  logic [7:0]            ir_q;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  mem_we;
  logic                  issue;
  logic                  unused_rsvd;

  logic                  len_ok, last_rep, last_pc, more_loops;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign unused_rsvd = ^wr_data_i[7:0];
  assign mem_we      = wr_en_i && (state_q == StIdle);

  assign len_ok     = (prog_len_i != '0) && (prog_len_i <= (ADDR_WIDTH+1)'(INST_DEPTH));
  assign last_rep   = (rep_q == ir_q[4:0]);
  assign last_pc    = ((ADDR_WIDTH+1)'(pc_q) + (ADDR_WIDTH+1)'(1)) == len_q;
  assign more_loops = ({1'b0, loop_q} + (LOOP_WIDTH+1)'(1)) < {1'b0, loops_q};
  assign pc_inc     = pc_q + ADDR_WIDTH'(1);

  // Program memory: write port only in idle, synchronous read into the instruction register.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_addr_i] <= wr_data_i[15:8];
    end
    if (rd_en) begin
      ir_q <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      rep_q    <= '0;
      loop_q   <= '0;
      len_q    <= '0;
      loops_q  <= '0;
      inst_v_o <= 1'b0;
      opcode_o <= 3'b000;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      wr_err_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rep_q    <= rep_d;
      loop_q   <= loop_d;
      len_q    <= len_d;
      loops_q  <= loops_d;
      inst_v_o <= inst_v_d;
      opcode_o <= opcode_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      wr_err_o <= wr_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rep_d   = rep_q;
    loop_d  = loop_q;
    len_d   = len_q;
    loops_d = loops_q;
    rd_en   = 1'b0;
    rd_addr = pc_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pc_d   = '0;
          rep_d  = '0;
          loop_d = '0;
          if (len_ok) begin
            len_d   = prog_len_i;
            loops_d = (num_loops_i == '0) ? LOOP_WIDTH'(1) : num_loops_i;
            state_d = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        rd_en   = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        if (!hold_i) begin
          issue = 1'b1;
          if (last_rep) begin
            // Prefetch the next word during the final repeat so the stream has no bubble.
            rep_d = '0;
            if (!last_pc) begin
              pc_d    = pc_inc;
              rd_en   = 1'b1;
              rd_addr = pc_inc;
            end else if (more_loops) begin
              loop_d  = loop_q + LOOP_WIDTH'(1);
              pc_d    = '0;
              rd_en   = 1'b1;
              rd_addr = '0;
            end else begin
              state_d = StDone;
            end
          end else begin
            rep_d = rep_q + 5'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      issue   = 1'b0;
    end
  end

  always_comb begin
    inst_v_d = issue;
    opcode_d = issue ? ir_q[7:5] : 3'b000;
    busy_d   = (state_d != StIdle);
    done_d   = (state_q == StDone) && !abort_i;
    wr_err_d = wr_err_o | (wr_en_i && (state_q != StIdle));
  end

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: per-cycle vector table plus an opcode scoreboard fed from a program model.
module tb_inst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  prog_len;
  logic [7:0]  num_loops;
  logic        start, hold, abort;
  logic        inst_v;
  logic [2:0]  opcode;
  logic        busy, done, wr_err;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [2:0] prog_op[3];
  int         prog_r[3];

  typedef struct {
    logic       start;
    logic       hold;
    logic       abort;
    logic [5:0] len;
    logic [7:0] loops;
    logic       ev;
    logic [2:0] eop;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  inst_seq dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .prog_len_i (prog_len),
    .num_loops_i(num_loops),
    .start_i    (start),
    .hold_i     (hold),
    .abort_i    (abort),
    .inst_v_o   (inst_v),
    .opcode_o   (opcode),
    .busy_o     (busy),
    .done_o     (done),
    .wr_err_o   (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected issue stream of the 3-word program for one run.
  task automatic push_run(input int loops);
    int n;
    n = (loops == 0) ? 1 : loops;
    for (int l = 0; l < n; l++)
      for (int i = 0; i < 3; i++)
        for (int r = 0; r <= prog_r[i]; r++) exp_q.push_back(prog_op[i]);
  endtask

  // Advance one clock and sample just after the edge; every issue is scored against the model.
  task automatic tick();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (inst_v === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_issue: got opcode %0d, expected no issue", opcode);
      end else begin
        e = exp_q.pop_front();
        if (opcode !== e) begin
          errors++;
          $display("FAIL sb_opcode: got %0d, expected %0d", opcode, e);
        end
      end
    end
  endtask

  task automatic v(input logic s, input logic h, input logic a, input logic [5:0] len,
                   input logic [7:0] loops, input logic ev, input logic [2:0] eop,
                   input logic eb, input logic ed);
    vec_t r;
    r.start = s; r.hold = h; r.abort = a; r.len = len; r.loops = loops;
    r.ev = ev; r.eop = eop; r.eb = eb; r.ed = ed;
    vecs.push_back(r);
  endtask

  task automatic run_until_done(output int issues, output bit seen);
    issues = 0;
    seen   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      start = 1'b0;
      if (inst_v === 1'b1) issues++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  issues;
    bit  seen;

    prog_op[0] = 3'b001; prog_r[0] = 0;
    prog_op[1] = 3'b100; prog_r[1] = 2;
    prog_op[2] = 3'b010; prog_r[2] = 0;

    // Basic program, single pass: issues on cycles 2..6, done on 7.
    v(1,0,0,3,1, 0,0,1,0); v(0,0,0,3,1, 0,0,1,0);
    v(0,0,0,3,1, 1,1,1,0); v(0,0,0,3,1, 1,4,1,0); v(0,0,0,3,1, 1,4,1,0);
    v(0,0,0,3,1, 1,4,1,0); v(0,0,0,3,1, 1,2,1,0);
    v(0,0,0,3,1, 0,0,0,1); v(0,0,0,3,1, 0,0,0,0);
    // Two passes: 10 contiguous issues, single done.
    v(1,0,0,3,2, 0,0,1,0); v(0,0,0,3,2, 0,0,1,0);
    v(0,0,0,3,2, 1,1,1,0); v(0,0,0,3,2, 1,4,1,0); v(0,0,0,3,2, 1,4,1,0);
    v(0,0,0,3,2, 1,4,1,0); v(0,0,0,3,2, 1,2,1,0);
    v(0,0,0,3,2, 1,1,1,0); v(0,0,0,3,2, 1,4,1,0); v(0,0,0,3,2, 1,4,1,0);
    v(0,0,0,3,2, 1,4,1,0); v(0,0,0,3,2, 1,2,1,0);
    v(0,0,0,3,2, 0,0,0,1); v(0,0,0,3,2, 0,0,0,0);
    // Hold for 3 cycles during the second MUL repeat.
    v(1,0,0,3,1, 0,0,1,0); v(0,0,0,3,1, 0,0,1,0);
    v(0,0,0,3,1, 1,1,1,0); v(0,0,0,3,1, 1,4,1,0);
    v(0,1,0,3,1, 0,0,1,0); v(0,1,0,3,1, 0,0,1,0); v(0,1,0,3,1, 0,0,1,0);
    v(0,0,0,3,1, 1,4,1,0); v(0,0,0,3,1, 1,4,1,0); v(0,0,0,3,1, 1,2,1,0);
    v(0,0,0,3,1, 0,0,0,1); v(0,0,0,3,1, 0,0,0,0);
    // Abort after the third issue: idle next cycle, no done.
    v(1,0,0,3,1, 0,0,1,0); v(0,0,0,3,1, 0,0,1,0);
    v(0,0,0,3,1, 1,1,1,0); v(0,0,0,3,1, 1,4,1,0); v(0,0,0,3,1, 1,4,1,0);
    v(0,0,1,3,1, 0,0,0,0); v(0,0,0,3,1, 0,0,0,0); v(0,0,0,3,1, 0,0,0,0);
    // num_loops=0 acts as 1; hold in fetch, done and idle has no effect.
    v(1,0,0,3,0, 0,0,1,0); v(0,1,0,3,0, 0,0,1,0);
    v(0,0,0,3,0, 1,1,1,0); v(0,0,0,3,0, 1,4,1,0); v(0,0,0,3,0, 1,4,1,0);
    v(0,0,0,3,0, 1,4,1,0); v(0,0,0,3,0, 1,2,1,0);
    v(0,1,0,3,0, 0,0,0,1); v(0,1,0,3,0, 0,0,0,0);
    // Out-of-range lengths go straight to done.
    v(1,0,0,0,1, 0,0,1,0); v(0,0,0,0,1, 0,0,0,1); v(0,0,0,0,1, 0,0,0,0);
    v(1,0,0,33,1, 0,0,1,0); v(0,0,0,33,1, 0,0,0,1); v(0,0,0,33,1, 0,0,0,0);

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0; num_loops = '0;
    start = 1'b0; hold = 1'b0; abort = 1'b0;
    #12;
    check("rst_inst_v", inst_v, 0);
    check("rst_opcode", opcode, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = {prog_op[i], 5'(prog_r[i]), 8'hA5};
      tick();
    end
    wr_en = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; hold = vecs[i].hold; abort = vecs[i].abort;
      prog_len = vecs[i].len; num_loops = vecs[i].loops;
      if (vecs[i].start && vecs[i].len >= 1 && vecs[i].len <= 32) push_run(int'(vecs[i].loops));
      if (vecs[i].abort) exp_q.delete();
      tick();
      check($sformatf("vec%0d_inst_v", i), inst_v, vecs[i].ev);
      check($sformatf("vec%0d_opcode", i), opcode, vecs[i].eop);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
      check($sformatf("vec%0d_done", i), done, vecs[i].ed);
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0;
    check("table_sb_drain", exp_q.size(), 0);
    check("table_wr_err", wr_err, 0);

    // Write while busy is dropped and flags wr_err; the run still replays the original MUL.
    prog_len = 6'd3; num_loops = 8'd1; start = 1'b1;
    push_run(1);
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = {3'b111, 5'd0, 8'h00};
    tick();
    wr_en = 1'b0;
    check("wr_err_set", wr_err, 1);
    run_until_done(issues, seen);
    check("wr_busy_done", seen, 1);
    check("wr_busy_issues", issues, 5);
    check("wr_busy_sb_drain", exp_q.size(), 0);
    tick();
    check("wr_err_sticky", wr_err, 1);

    // Asynchronous reset mid-issue, then replay two passes.
    start = 1'b1;
    push_run(1);
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_inst_v", inst_v, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_inst_v", inst_v, 0);
    check("arst_opcode", opcode, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_wr_err", wr_err, 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    num_loops = 8'd2; start = 1'b1;
    push_run(2);
    run_until_done(issues, seen);
    check("replay_done", seen, 1);
    check("replay_issues", issues, 10);
    check("replay_sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_seq.md
INST_SEQ -- requirements
Module: inst_seq

Interface
REQ-001 SHALL have parameter INST_DEPTH, default 32, program memory depth in words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, equal to log2(INST_DEPTH).
REQ-003 SHALL have parameter LOOP_WIDTH, default 8, width of the loop count.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  program-memory write strobe.
REQ-007 wr_addr  input  ADDR_WIDTH  program-memory write address.
REQ-008 wr_data  input  16  instruction word: [15:13] opcode, [12:8] repeat count R, [7:0] reserved (ignored).
REQ-009 prog_len  input  ADDR_WIDTH+1  number of instructions in the program, sampled at start.
REQ-010 num_loops  input  LOOP_WIDTH  program passes to run, sampled at start; 0 treated as 1.
REQ-011 start  input  1  one-cycle start request.
REQ-012 hold  input  1  downstream stall request.
REQ-013 abort  input  1  terminate the running program.
REQ-014 inst_v  output  1  instruction-valid strobe, feeds the decoder's inst_v.
REQ-015 opcode  output  3  opcode, feeds the decoder's opcode.
REQ-016 busy  output  1  high from the start acceptance until return to IDLE.
REQ-017 done  output  1  one-cycle pulse on normal completion.
REQ-018 wr_err  output  1  sticky flag: write attempted while busy.

Function
REQ-019 SHALL implement FSM IDLE -> FETCH -> ISSUE -> DONE -> IDLE.
REQ-020 SHALL register all outputs; opcode SHALL be 3'b000 (LOAD/NOP) whenever inst_v=0.
REQ-021 SHALL write wr_data to memory[wr_addr] on wr_en only in IDLE; writes in other states are dropped and set wr_err.
REQ-022 SHALL accept start only in IDLE with prog_len in 1..INST_DEPTH: latch prog_len and num_loops, set pc=0, loop_cnt=0, go to FETCH; busy=1 from the next cycle.
REQ-023 start with prog_len=0 or >INST_DEPTH SHALL go directly to DONE: done pulses, no inst_v.
REQ-024 start while not in IDLE SHALL be ignored.
REQ-025 memory read SHALL be synchronous, one cycle; FETCH lasts one cycle, then ISSUE.
REQ-026 first inst_v SHALL be high exactly 2 cycles after the start edge; that is total latency 2.
REQ-027 each instruction SHALL issue on R+1 consecutive inst_v cycles with the same opcode.
REQ-028 the next instruction SHALL be prefetched during the last issue cycle, so successive instructions are issued without bubbles.
REQ-029 after the last issue of pc=prog_len-1: if loop_cnt+1 < num_loops, SHALL increment loop_cnt and wrap pc to 0 with no bubble; otherwise go to DONE.
REQ-030 DONE SHALL last one cycle with done=1, inst_v=0, then go to IDLE with busy=0.
REQ-031 hold=1 in ISSUE SHALL force inst_v=0 and opcode=000 in the following cycle and freeze pc, repeat counter and loop_cnt.
REQ-032 on release of hold, issue SHALL resume with the instruction and remaining repeats exactly where it stopped; no instruction is lost or duplicated.
REQ-033 hold in IDLE, FETCH or DONE SHALL have no effect.
REQ-034 abort in any non-IDLE state SHALL go to IDLE next cycle with inst_v=0, busy=0 and done=0.
REQ-035 abort SHALL have priority over hold; hold SHALL have priority over issue progress.
REQ-036 the total inst_v count per run SHALL be num_loops × Σ(R_i+1).

Reset
REQ-037 rst SHALL asynchronously force IDLE, inst_v=0, opcode=000, busy=0, done=0, wr_err=0, pc=0, loop_cnt=0.
REQ-038 memory contents SHALL be unaffected by rst.
REQ-039 rst mid-program SHALL drop all pending issues; a new start is required afterwards.

Verification
REQ-040 Load {ADD R=0, MUL R=2, SUB R=0}, prog_len=3, num_loops=1, start at cycle 0 -> inst_v cycles 2..6, opcodes 001,100,100,100,010; done at cycle 7.
REQ-041 Same program with num_loops=2 -> 10 contiguous inst_v cycles, pc wraps without a bubble, single done pulse.
REQ-042 hold=1 for 3 cycles during the second MUL repeat -> inst_v low and opcode=000 for those 3 cycles, then the remaining MUL repeats and SUB follow; total 5 issues.
REQ-043 abort on the third issue cycle -> inst_v=0 and busy=0 next cycle, no done; a subsequent start runs the program normally.
REQ-044 wr_en while busy -> memory unchanged, wr_err=1 until rst; start with prog_len=0 -> done 1 cycle after start, no inst_v.
REQ-045 rst asserted mid-ISSUE, asynchronously -> outputs go to reset values immediately, without a clock edge; the program survives rst and replays correctly.
